// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types, constants and helpers for the countdown timer.
//               - state_e      : controller state encoding
//               - C_PRE*_DEF   : default prescaler ratios for a 50 MHz board
//               - sat9()       : clamps a 4-bit switch preset to 0..9
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Controller states; the encoding is fixed so it can be probed on a
    // logic analyser with a known mapping.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_e;

    // 50 MHz -> 1 kHz, then 1 kHz -> 1 Hz.
    localparam int unsigned C_PRE1_DEF = 50000;
    localparam int unsigned C_PRE2_DEF = 1000;

    // Display and preset widths.
    localparam int unsigned C_LED_W = 10;
    localparam int unsigned C_SW_W  = 4;

    // Bit positions of the two keys inside the synchroniser vectors.
    localparam int unsigned C_KEY_START = 0;
    localparam int unsigned C_KEY_CLEAR = 1;

    // The display only has ten positions, so presets above 9 clamp to 9.
    function automatic logic [C_SW_W-1:0] sat9(input logic [C_SW_W-1:0] v);
        logic [C_SW_W-1:0] r;
        r = (v > 4'd9) ? 4'd9 : v;
        return r;
    endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : timer_prescaler
// Description : Two-stage timebase divider.
//               Stage 1 counts clk cycles 0..PRE1-1 and strobes ms_tick_o on
//               its last count. Stage 2 counts ms ticks 0..PRE2-1.
//               sec_tick_o fires on the ms tick that wraps stage 2;
//               half_tick_o fires on the ms tick at stage 2 == PRE2/2-1.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               en_i          - advance the counters
//               clr_i         - synchronous clear of both stages (wins)
//               ms_tick_o     - one-cycle stage-1 terminal strobe
//               sec_tick_o    - one-cycle stage-2 terminal strobe
//               half_tick_o   - one-cycle mid-second strobe
// Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned PRE1 = C_PRE1_DEF,
    parameter int unsigned PRE2 = C_PRE2_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic ms_tick_o,
    output logic sec_tick_o,
    output logic half_tick_o
);

    localparam int unsigned C_W1 = (PRE1 > 1) ? $clog2(PRE1) : 1;
    localparam int unsigned C_W2 = (PRE2 > 1) ? $clog2(PRE2) : 1;

    localparam logic [C_W1-1:0] C_S1_LAST = C_W1'(PRE1 - 1);
    localparam logic [C_W2-1:0] C_S2_LAST = C_W2'(PRE2 - 1);
    // Guard against PRE2 == 1, where there is no meaningful mid-second.
    localparam logic [C_W2-1:0] C_S2_HALF = C_W2'((PRE2 >= 2) ? (PRE2 / 2 - 1) : 0);

    logic [C_W1-1:0] stage1_q, stage1_d;
    logic [C_W2-1:0] stage2_q, stage2_d;
    logic            ms_tick;

    // Ticks are qualified by en_i so a frozen counter parked on a terminal
    // value cannot emit a continuous strobe while paused.
    assign ms_tick     = en_i && (stage1_q == C_S1_LAST);
    assign ms_tick_o   = ms_tick;
    assign sec_tick_o  = ms_tick && (stage2_q == C_S2_LAST);
    assign half_tick_o = ms_tick && (stage2_q == C_S2_HALF);

    always_comb begin
        stage1_d = stage1_q;
        stage2_d = stage2_q;
        if (clr_i) begin
            stage1_d = '0;
            stage2_d = '0;
        end else if (en_i) begin
            if (ms_tick) begin
                stage1_d = '0;
                if (stage2_q == C_S2_LAST) begin
                    stage2_d = '0;
                end else begin
                    stage2_d = stage2_q + C_W2'(1);
                end
            end else begin
                stage1_d = stage1_q + C_W1'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

endmodule : timer_prescaler
`default_nettype wire

// File: rtl/countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : countdown_ctrl
// Description : Countdown-timer controller. Loads a 0..9 second preset from
//               the slide switches, counts it down at 1 Hz via the shared
//               prescaler and raises a blinking alarm on expiry. Start toggles
//               run/pause and acknowledges the alarm; clear aborts to idle.
// Ports       : clk          - system clock (50 MHz)
//               rst          - asynchronous active-high reset
//               key_start_n  - raw start key, active low, asynchronous
//               key_clear_n  - raw clear key, active low, asynchronous
//               sw[3:0]      - preset seconds (10..15 clamp to 9)
//               led[9:0]     - one-hot remaining count, all blink in alarm
//               alarm        - high while in ALARM
//               busy         - high while in RUN or PAUSE
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned PRE1 = C_PRE1_DEF,
    parameter int unsigned PRE2 = C_PRE2_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_start_n,
    input  logic               key_clear_n,
    input  logic [C_SW_W-1:0]  sw,
    output logic [C_LED_W-1:0] led,
    output logic               alarm,
    output logic               busy
);

    // ------------------------------------------------------------------
    // Key synchronisation and press detection
    // ------------------------------------------------------------------
    // Both keys share one vector per pipeline stage. Flops reset to 1 so a
    // key held low across reset is seen as a fresh press once released
    // from reset, and nothing fires spuriously on reset release.
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] hist_q;
    logic [1:0] press_q;

    logic start_pulse;
    logic clear_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            hist_q  <= 2'b11;
            press_q <= 2'b00;
        end else begin
            sync1_q <= {key_clear_n, key_start_n};
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            // Registered so the pulse lands two edges after the raw sample
            // and the FSM reacts on the third.
            press_q <= hist_q & ~sync2_q;
        end
    end

    assign start_pulse = press_q[C_KEY_START];
    assign clear_pulse = press_q[C_KEY_CLEAR];

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    state_e state_q, state_d;

    logic presc_en;
    logic presc_clr;
    logic ms_tick;
    logic sec_tick;
    logic half_tick;
    logic blink_toggle;

    // Idle holds the timebase at zero so every run starts on a whole second.
    // Pause simply withholds the enable, preserving the partial second.
    assign presc_en  = (state_q == ST_RUN) || (state_q == ST_ALARM);
    assign presc_clr = (state_q == ST_IDLE) || clear_pulse;

    timer_prescaler #(
        .PRE1 (PRE1),
        .PRE2 (PRE2)
    ) u_prescaler (
        .clk         (clk),
        .rst         (rst),
        .en_i        (presc_en),
        .clr_i       (presc_clr),
        .ms_tick_o   (ms_tick),
        .sec_tick_o  (sec_tick),
        .half_tick_o (half_tick)
    );

    // Both blink events coincide with a ms strobe; two toggles per second
    // give a 1 Hz on/off pattern.
    assign blink_toggle = ms_tick && (sec_tick || half_tick);

    // ------------------------------------------------------------------
    // FSM, down-counter and blink
    // ------------------------------------------------------------------
    logic [C_SW_W-1:0] count_q, count_d;
    logic [C_SW_W-1:0] preset;
    logic              blink_q, blink_d;

    assign preset = sat9(sw);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        blink_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                count_d = preset;
                if (start_pulse) begin
                    // A zero preset has nothing to count; expire at once.
                    state_d = (preset == 4'd0) ? ST_ALARM : ST_RUN;
                end
            end

            ST_RUN: begin
                if (sec_tick) begin
                    count_d = count_q - 4'd1;
                end
                // Expiry takes precedence over a coincident pause request.
                if (sec_tick && (count_q == 4'd1)) begin
                    state_d = ST_ALARM;
                end else if (start_pulse) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (start_pulse) begin
                    state_d = ST_RUN;
                end
            end

            ST_ALARM: begin
                count_d = '0;
                blink_d = blink_q ^ blink_toggle;
                if (start_pulse) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear overrides whatever the state logic decided, including a
        // start pulse in the same cycle.
        if (clear_pulse) begin
            state_d = ST_IDLE;
            count_d = preset;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    // alarm/busy follow the next state so they move on the same edge as
    // the FSM. led is decoded from the already-registered count and blink,
    // which puts it one edge behind the counter.
    logic [C_LED_W-1:0] led_q, led_d;
    logic               alarm_q, alarm_d;
    logic               busy_q, busy_d;

    always_comb begin
        led_d = {{(C_LED_W-1){1'b0}}, 1'b1} << count_q;
        if (state_q == ST_ALARM) begin
            led_d = {C_LED_W{blink_q}};
        end
        alarm_d = (state_d == ST_ALARM);
        busy_d  = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            blink_q <= 1'b0;
            led_q   <= {{(C_LED_W-1){1'b0}}, 1'b1};
            alarm_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            blink_q <= blink_d;
            led_q   <= led_d;
            alarm_q <= alarm_d;
            busy_q  <= busy_d;
        end
    end

    assign led   = led_q;
    assign alarm = alarm_q;
    assign busy  = busy_q;

endmodule : countdown_ctrl
`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_ctrl
// Description : Self-checking bench for countdown_ctrl with PRE1=5, PRE2=4
//               (20 cycles per second). A behavioural model tracks the timer
//               as "seconds remaining" plus "RUN cycles into the current
//               second", and the keys as a delay line of raw samples.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_ctrl;

    localparam int PRE1    = 5;
    localparam int PRE2    = 4;
    localparam int SEC_CYC = PRE1 * PRE2;
    localparam int HALF_AT = (PRE2 / 2 - 1) * PRE1 + (PRE1 - 1);

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ALARM = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_start_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic [3:0] sw = 4'd0;
    logic [9:0] led;
    logic       alarm;
    logic       busy;

    countdown_ctrl #(
        .PRE1 (PRE1),
        .PRE2 (PRE2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_start_n (key_start_n),
        .key_clear_n (key_clear_n),
        .sw          (sw),
        .led         (led),
        .alarm       (alarm),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    string tag    = "init";

    // Model state
    int       m_st;
    int       m_secs;
    int       m_phase;
    bit       m_blink;
    logic [9:0] m_led;
    logic     m_alarm;
    logic     m_busy;
    bit       ks[3];
    bit       kc[3];
    bit       m_sp;
    bit       m_cp;

    task automatic model_reset();
        m_st    = M_IDLE;
        m_secs  = 0;
        m_phase = 0;
        m_blink = 0;
        m_led   = 10'h001;
        m_alarm = 1'b0;
        m_busy  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ks[i] = 1'b1;
            kc[i] = 1'b1;
        end
        m_sp = 0;
        m_cp = 0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_update();
        int st_n, secs_n, ph_n, preset;
        bit bl_n, en, tick, half, sp_n, cp_n;
        if (rst) begin
            model_reset();
        end else begin
            preset = (sw > 4'd9) ? 9 : int'(sw);
            en     = (m_st == M_RUN) || (m_st == M_ALARM);
            tick   = en && (m_phase == SEC_CYC - 1);
            half   = en && (m_phase == HALF_AT);

            st_n   = m_st;
            secs_n = m_secs;
            case (m_st)
                M_IDLE: begin
                    secs_n = preset;
                    if (m_sp) st_n = (preset == 0) ? M_ALARM : M_RUN;
                end
                M_RUN: begin
                    if (tick) secs_n = m_secs - 1;
                    if (tick && m_secs == 1) st_n = M_ALARM;
                    else if (m_sp) st_n = M_PAUSE;
                end
                M_PAUSE: if (m_sp) st_n = M_RUN;
                default: begin
                    secs_n = 0;
                    if (m_sp) st_n = M_IDLE;
                end
            endcase
            if (m_cp) begin
                st_n   = M_IDLE;
                secs_n = preset;
            end

            if (m_st == M_IDLE || m_cp) ph_n = 0;
            else if (en)                ph_n = (m_phase + 1) % SEC_CYC;
            else                        ph_n = m_phase;

            bl_n = (m_st == M_ALARM) ? (m_blink ^ (tick | half)) : 1'b0;

            m_led   = (m_st == M_ALARM) ? (m_blink ? 10'h3FF : 10'h000)
                                        : (10'h001 << m_secs);
            m_alarm = (st_n == M_ALARM);
            m_busy  = (st_n == M_RUN) || (st_n == M_PAUSE);

            // A press is registered when the sample three edges back was high
            // and the sample two edges back was low.
            sp_n  = ks[2] & ~ks[1];
            cp_n  = kc[2] & ~kc[1];
            ks[2] = ks[1]; ks[1] = ks[0]; ks[0] = key_start_n;
            kc[2] = kc[1]; kc[1] = kc[0]; kc[0] = key_clear_n;

            m_st    = st_n;
            m_secs  = secs_n;
            m_phase = ph_n;
            m_blink = bl_n;
            m_sp    = sp_n;
            m_cp    = cp_n;
        end
    endtask

    task automatic check_outputs();
        checks++;
        assert (led === m_led) else begin
            errors++;
            $error("FAIL %s led got %h expected %h", tag, led, m_led);
        end
        checks++;
        assert (alarm === m_alarm) else begin
            errors++;
            $error("FAIL %s alarm got %b expected %b", tag, alarm, m_alarm);
        end
        checks++;
        assert (busy === m_busy) else begin
            errors++;
            $error("FAIL %s busy got %b expected %b", tag, busy, m_busy);
        end
    endtask

    task automatic expect_val(input string name, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_update();
            #1;
            check_outputs();
        end
    endtask

    // Raw key low for exactly one sampled edge (k); returns after edge k+2,
    // so the next cycle(1) is the edge on which the FSM reacts.
    task automatic press_start();
        key_start_n = 1'b0;
        cycle(1);
        key_start_n = 1'b1;
        cycle(2);
    endtask

    initial begin
        int first4, first2, first_alarm, first_on, n;

        model_reset();

        // ---------------- Reset values ----------------
        tag = "reset";
        #2 rst = 1'b1;
        #1;
        expect_val("reset_led", int'(led), 'h001);
        expect_val("reset_alarm", int'(alarm), 0);
        expect_val("reset_busy", int'(busy), 0);
        cycle(3);
        @(negedge clk);
        rst = 1'b0;
        cycle(2);

        // ---------------- Saturated preset ----------------
        tag = "sat_preset";
        sw  = 4'd12;
        cycle(3);
        expect_val("sat_led", int'(led), 'h200);

        // ---------------- Full countdown ----------------
        tag = "countdown";
        sw  = 4'd3;
        cycle(3);
        press_start();
        expect_val("busy_before_k3", int'(busy), 0);
        cycle(1);
        expect_val("busy_at_k3", int'(busy), 1);
        expect_val("led_start", int'(led), 'h008);
        first4 = -1; first2 = -1; first_alarm = -1; first_on = -1;
        for (int e = 1; e <= 90; e++) begin
            cycle(1);
            if (first4 < 0 && led === 10'h004) first4 = e;
            if (first2 < 0 && led === 10'h002) first2 = e;
            if (first_alarm < 0 && alarm === 1'b1) first_alarm = e;
            if (first_on < 0 && led === 10'h3FF) first_on = e;
        end
        expect_val("first_decrement", first4, 21);
        expect_val("second_decrement", first2, 41);
        expect_val("alarm_edge", first_alarm, 60);
        expect_val("blink_on_edge", first_on, 71);
        expect_val("blink_off_at_90", int'(led), 'h000);

        // ---------------- Alarm acknowledge with long hold ----------------
        tag = "ack_hold";
        key_start_n = 1'b0;
        cycle(100);
        key_start_n = 1'b1;
        cycle(6);
        expect_val("ack_alarm", int'(alarm), 0);
        expect_val("ack_busy", int'(busy), 0);
        expect_val("ack_led", int'(led), 'h008);

        // ---------------- Pause / resume ----------------
        tag = "pause";
        sw  = 4'd2;
        cycle(3);
        press_start();
        cycle(1);                // enter RUN
        cycle(3);
        press_start();
        cycle(1);                // PAUSE after 7 RUN cycles
        expect_val("paused_busy", int'(busy), 1);
        cycle(50);
        expect_val("paused_led", int'(led), 'h004);
        press_start();
        cycle(1);                // back in RUN
        n = -1;
        for (int e = 1; e <= 40; e++) begin
            cycle(1);
            if (n < 0 && led === 10'h002) n = e;
        end
        expect_val("resume_decrement", n, 14);
        cycle(30);

        // ---------------- Clear beats start ----------------
        tag = "clear_prio";
        sw  = 4'd5;
        cycle(3);
        press_start();
        cycle(6);
        key_start_n = 1'b0;
        key_clear_n = 1'b0;
        cycle(1);
        key_start_n = 1'b1;
        key_clear_n = 1'b1;
        cycle(3);
        expect_val("clear_busy", int'(busy), 0);
        cycle(1);
        expect_val("clear_led", int'(led), 'h020);

        // ---------------- Zero preset ----------------
        tag = "zero_preset";
        sw  = 4'd0;
        cycle(3);
        press_start();
        cycle(1);
        expect_val("zero_alarm", int'(alarm), 1);
        expect_val("zero_busy", int'(busy), 0);
        cycle(25);
        press_start();
        cycle(3);

        // ---------------- Reset mid-count, key held through reset --------
        tag = "mid_reset";
        sw  = 4'd4;
        cycle(2);
        press_start();
        cycle(15);
        #3;
        rst = 1'b1;
        key_start_n = 1'b0;
        #1;
        model_reset();
        expect_val("midrst_led", int'(led), 'h001);
        expect_val("midrst_alarm", int'(alarm), 0);
        expect_val("midrst_busy", int'(busy), 0);
        cycle(3);
        @(negedge clk);
        rst = 1'b0;
        cycle(10);
        expect_val("held_key_one_press", int'(busy), 1);
        key_start_n = 1'b1;
        cycle(5);
        key_clear_n = 1'b0;
        cycle(1);
        key_clear_n = 1'b1;
        cycle(5);

        // ---------------- Randomised traffic ----------------
        tag = "random";
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 24) == 0) key_start_n = ~key_start_n;
            if ($urandom_range(0, 299) == 0) key_clear_n = 1'b0;
            else if ($urandom_range(0, 3) == 0) key_clear_n = 1'b1;
            if ($urandom_range(0, 59) == 0) sw = 4'($urandom_range(0, 15));
            cycle(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_countdown_ctrl
`default_nettype wire
